// File: rtl/frame_cfg_pkg.sv
// Shared types and constants for the column frame loader.
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHK,
    ST_STROBE,
    ST_GUARD
  } state_e;

  localparam logic [7:0] FRAME_SYNC    = 8'hA5;
  localparam int         CFG_W         = 32;
  localparam int         HDR_SYNC_MSB  = 31;
  localparam int         HDR_SYNC_LSB  = 24;
  localparam int         HDR_IDX_MSB   = 7;
  localparam int         HDR_IDX_LSB   = 0;
  localparam int         FRAMES_DONE_W = 16;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Registered one-hot decode of a frame index; all-zero when en_i is low.
// One cycle from en_i/idx_i to strobe_o.
module frame_strobe_decoder
  import frame_cfg_pkg::*;
#(
  parameter int N    = 20,
  parameter int IdxW = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [IdxW-1:0] idx_i,
  output logic [N-1:0]    strobe_o
);

  logic [N-1:0] strobe_d, strobe_q;

  always_comb begin
    strobe_d = '0;
    for (int i = 0; i < N; i++) begin
      strobe_d[i] = en_i && (idx_i == IdxW'(i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) strobe_q <= '0;
    else       strobe_q <= strobe_d;
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/frame_strobe_sequencer.sv
// Assembles header + NumRows config words into FrameData and pulses one FrameStrobe line;
// strobe rises the cycle after the last accepted word. FRAME_CRC_EN adds an XOR check word.
module frame_strobe_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumRows         = 4,
  parameter int StrobeWidth     = 2
) (
  input  logic                               UserCLK,
  input  logic                               rst,
  input  logic [CFG_W-1:0]                   cfg_data,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               err,
  output logic [FRAMES_DONE_W-1:0]           frames_done
);

  localparam int IdxW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int ScW  = (StrobeWidth > 1) ? $clog2(StrobeWidth) : 1;

  state_e                           state_q, state_d;
  logic                             ready_q, ready_d;
  logic                             err_q, err_d;
  logic                             skip_q, skip_d;
  logic [IdxW-1:0]                  idx_q, idx_d;
  logic [RowW-1:0]                  row_q, row_d;
  logic [ScW-1:0]                   scnt_q, scnt_d;
  logic [FRAMES_DONE_W-1:0]         fd_q, fd_d;
  logic [NumRows*FrameBitsPerRow-1:0] frame_q, frame_d;
  logic                             frame_wr;
`ifdef FRAME_CRC_EN
  logic [CFG_W-1:0]                 acc_q, acc_d;
`endif

  logic       hs;
  logic [7:0] hdr_idx;
  logic       idx_ok;

  assign hs      = cfg_valid && ready_q;
  assign hdr_idx = cfg_data[HDR_IDX_MSB:HDR_IDX_LSB];
  assign idx_ok  = 32'(hdr_idx) < MaxFramesPerCol;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    skip_d   = skip_q;
    idx_d    = idx_q;
    row_d    = row_q;
    scnt_d   = scnt_q;
    frame_wr = 1'b0;
`ifdef FRAME_CRC_EN
    acc_d    = acc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (cfg_data[HDR_SYNC_MSB:HDR_SYNC_LSB] == FRAME_SYNC) begin
            skip_d  = !idx_ok;
            if (idx_ok) idx_d = IdxW'(hdr_idx);
            else        err_d = 1'b1;
            row_d   = '0;
            state_d = ST_LOAD;
`ifdef FRAME_CRC_EN
            acc_d   = cfg_data;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (hs) begin
          frame_wr = !skip_q;
`ifdef FRAME_CRC_EN
          acc_d    = acc_q ^ cfg_data;
`endif
          if (row_q == RowW'(NumRows - 1)) begin
            row_d  = '0;
            scnt_d = '0;
`ifdef FRAME_CRC_EN
            state_d = skip_q ? ST_IDLE : ST_CHK;
`else
            state_d = skip_q ? ST_IDLE : ST_STROBE;
`endif
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end
`ifdef FRAME_CRC_EN
      ST_CHK: begin
        if (hs) begin
          if (cfg_data == acc_q) begin
            state_d = ST_STROBE;
            scnt_d  = '0;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_STROBE: begin
        if (scnt_q == ScW'(StrobeWidth - 1)) state_d = ST_GUARD;
        else                                 scnt_d  = scnt_q + ScW'(1);
      end
      ST_GUARD: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Ready is registered from the next state so it never depends on cfg_valid.
    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_CHK);
    fd_d    = fd_q;
    if (state_d == ST_STROBE && state_q != ST_STROBE && fd_q != '1) fd_d = fd_q + 16'd1;

    frame_d = frame_q;
    for (int r = 0; r < NumRows; r++) begin
      if (frame_wr && row_q == RowW'(r)) frame_d[r*FrameBitsPerRow +: FrameBitsPerRow] = cfg_data;
    end
  end

  always_ff @(posedge UserCLK) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      skip_q  <= 1'b0;
      idx_q   <= '0;
      row_q   <= '0;
      scnt_q  <= '0;
      fd_q    <= '0;
      frame_q <= '0;
`ifdef FRAME_CRC_EN
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      skip_q  <= skip_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      scnt_q  <= scnt_d;
      fd_q    <= fd_d;
      frame_q <= frame_d;
`ifdef FRAME_CRC_EN
      acc_q   <= acc_d;
`endif
    end
  end

  frame_strobe_decoder #(
    .N    (MaxFramesPerCol),
    .IdxW (IdxW)
  ) u_dec (
    .clk_i    (UserCLK),
    .rst_i    (rst),
    .en_i     (state_d == ST_STROBE),
    .idx_i    (idx_q),
    .strobe_o (FrameStrobe)
  );

  assign cfg_ready   = ready_q;
  assign busy        = (state_q != ST_IDLE);
  assign err         = err_q;
  assign frames_done = fd_q;
  assign FrameData   = frame_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Directed bench: vector table for normal/bad-index/bad-sync frames, hand sequences for stalls and reset.
module tb_frame_strobe_sequencer;

  logic         UserCLK;
  logic         rst;
  logic [31:0]  cfg_data;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [127:0] FrameData;
  logic [19:0]  FrameStrobe;
  logic         busy;
  logic         err;
  logic [15:0]  frames_done;

  int tests = 0;
  int fails = 0;

  frame_strobe_sequencer dut (
    .UserCLK     (UserCLK),
    .rst         (rst),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err),
    .frames_done (frames_done)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  typedef struct {
    logic         vld;
    logic [31:0]  dat;
    logic         rdy;
    logic [19:0]  stb;
    logic         bsy;
    logic         er;
    logic [15:0]  fd;
    logic         chk_frame;
    logic [127:0] frame;
  } vec_t;

  vec_t vq[$];

  localparam logic [127:0] F3 = 128'h00000004_00000003_00000002_00000001;
  localparam logic [127:0] F1 = 128'h00000044_00000033_00000022_00000011;

  task automatic add(input logic vld, input logic [31:0] dat, input logic rdy, input logic [19:0] stb,
                     input logic bsy, input logic er, input logic [15:0] fd,
                     input logic cf, input logic [127:0] fr);
    vec_t v;
    v.vld = vld; v.dat = dat; v.rdy = rdy; v.stb = stb; v.bsy = bsy;
    v.er = er; v.fd = fd; v.chk_frame = cf; v.frame = fr;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge UserCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic rdy, input logic [19:0] stb,
                          input logic bsy, input logic er, input logic [15:0] fd);
    chk({name, ".cfg_ready"}, 128'(cfg_ready), 128'(rdy));
    chk({name, ".FrameStrobe"}, 128'(FrameStrobe), 128'(stb));
    chk({name, ".busy"}, 128'(busy), 128'(bsy));
    chk({name, ".err"}, 128'(err), 128'(er));
    chk({name, ".frames_done"}, 128'(frames_done), 128'(fd));
  endtask

  task automatic drive(input logic vld, input logic [31:0] dat);
    cfg_valid = vld;
    cfg_data  = vld ? dat : 32'hFFFF_FFFF;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0);
    step();
    chk_outs("reset", 1'b0, 20'h0, 1'b0, 1'b0, 16'd0);
    chk("reset.FrameData", FrameData, 128'h0);
    rst = 1'b0;
    step();
    chk_outs("post_reset", 1'b1, 20'h0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0);
    step();
    do_reset();

`ifdef FRAME_CRC_EN
    // Good check word: strobe bit 0.
    drive(1'b1, 32'hA5000000); step();
    for (int k = 1; k <= 4; k++) begin drive(1'b1, 32'(k)); step(); end
    chk_outs("crc_before_chk", 1'b1, 20'h0, 1'b1, 1'b0, 16'd0);
    drive(1'b1, 32'hA5000004); step();
    chk_outs("crc_good", 1'b0, 20'h00001, 1'b1, 1'b0, 16'd1);
    chk("crc_good.FrameData", FrameData, F3);
    drive(1'b0, 32'h0);
    for (int k = 0; k < 3; k++) step();
    chk_outs("crc_good_idle", 1'b1, 20'h0, 1'b0, 1'b0, 16'd1);
    // Bad check word: no strobe, err set.
    drive(1'b1, 32'hA5000000); step();
    for (int k = 1; k <= 4; k++) begin drive(1'b1, 32'(k)); step(); end
    drive(1'b1, 32'h0); step();
    chk_outs("crc_bad", 1'b1, 20'h0, 1'b0, 1'b1, 16'd1);
    drive(1'b0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("crc_bad.no_strobe", 128'(FrameStrobe), 128'h0);
    end
`else
    // Normal frame to index 3.
    add(1, 32'hA5000003, 1, 20'h0,     1, 0, 16'd0, 0, 128'h0);
    add(1, 32'd1,        1, 20'h0,     1, 0, 16'd0, 0, 128'h0);
    add(1, 32'd2,        1, 20'h0,     1, 0, 16'd0, 0, 128'h0);
    add(1, 32'd3,        1, 20'h0,     1, 0, 16'd0, 0, 128'h0);
    add(1, 32'd4,        0, 20'h00008, 1, 0, 16'd1, 1, F3);
    add(0, 32'h0,        0, 20'h00008, 1, 0, 16'd1, 0, 128'h0);
    add(0, 32'h0,        0, 20'h0,     1, 0, 16'd1, 1, F3);
    add(0, 32'h0,        1, 20'h0,     0, 0, 16'd1, 1, F3);
    // Index 20 is out of range: data skipped, no strobe.
    add(1, 32'hA5000014, 1, 20'h0,     1, 1, 16'd1, 0, 128'h0);
    add(1, 32'hDEADBEEF, 1, 20'h0,     1, 1, 16'd1, 0, 128'h0);
    add(1, 32'hDEADBEEF, 1, 20'h0,     1, 1, 16'd1, 0, 128'h0);
    add(1, 32'hDEADBEEF, 1, 20'h0,     1, 1, 16'd1, 0, 128'h0);
    add(1, 32'hDEADBEEF, 1, 20'h0,     0, 1, 16'd1, 1, F3);
    add(0, 32'h0,        1, 20'h0,     0, 1, 16'd1, 1, F3);
    // Bad sync dropped, then a valid frame to index 1.
    add(1, 32'h5A000001, 1, 20'h0,     0, 1, 16'd1, 0, 128'h0);
    add(1, 32'hA5000001, 1, 20'h0,     1, 1, 16'd1, 0, 128'h0);
    add(1, 32'h11,       1, 20'h0,     1, 1, 16'd1, 0, 128'h0);
    add(1, 32'h22,       1, 20'h0,     1, 1, 16'd1, 0, 128'h0);
    add(1, 32'h33,       1, 20'h0,     1, 1, 16'd1, 0, 128'h0);
    add(1, 32'h44,       0, 20'h00002, 1, 1, 16'd2, 1, F1);
    add(0, 32'h0,        0, 20'h00002, 1, 1, 16'd2, 0, 128'h0);
    add(0, 32'h0,        0, 20'h0,     1, 1, 16'd2, 0, 128'h0);
    add(0, 32'h0,        1, 20'h0,     0, 1, 16'd2, 1, F1);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].vld, vq[i].dat);
      step();
      chk_outs($sformatf("vec%0d", i), vq[i].rdy, vq[i].stb, vq[i].bsy, vq[i].er, vq[i].fd);
      if (vq[i].chk_frame) chk($sformatf("vec%0d.FrameData", i), FrameData, vq[i].frame);
    end

    // cfg_valid toggling through a frame to index 5.
    drive(1'b1, 32'hA5000005); step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0); step();
      chk($sformatf("toggle_gap%0d.rdy", k), 128'(cfg_ready), 128'h1);
      chk($sformatf("toggle_gap%0d.stb", k), 128'(FrameStrobe), 128'h0);
      drive(1'b1, 32'(k + 5)); step();
      if (k < 3) begin
        chk($sformatf("toggle_word%0d.rdy", k), 128'(cfg_ready), 128'h1);
        chk($sformatf("toggle_word%0d.stb", k), 128'(FrameStrobe), 128'h0);
      end
    end
    chk_outs("toggle_strobe", 1'b0, 20'h00020, 1'b1, 1'b1, 16'd3);
    chk("toggle.FrameData", FrameData, 128'h00000008_00000007_00000006_00000005);
    drive(1'b0, 32'h0);
    step(); chk("toggle_strobe2", 128'(FrameStrobe), 128'h00020);
    step(); chk("toggle_guard", 128'(FrameStrobe), 128'h0);
    step(); chk_outs("toggle_idle", 1'b1, 20'h0, 1'b0, 1'b1, 16'd3);

    // Reset after two data words discards the partial frame.
    drive(1'b1, 32'hA5000007); step();
    drive(1'b1, 32'hAAAA0001); step();
    drive(1'b1, 32'hAAAA0002); step();
    rst = 1'b1;
    drive(1'b1, 32'hAAAA0003); step();
    chk_outs("midrst", 1'b0, 20'h0, 1'b0, 1'b0, 16'd0);
    chk("midrst.FrameData", FrameData, 128'h0);
    rst = 1'b0;
    drive(1'b0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("midrst_quiet%0d", k), 128'(FrameStrobe), 128'h0);
    end
    // Full frame to the highest legal index after the reset.
    drive(1'b1, 32'hA5000013); step();
    drive(1'b1, 32'h0000000A); step();
    drive(1'b1, 32'h0000000B); step();
    drive(1'b1, 32'h0000000C); step();
    drive(1'b1, 32'h0000000D); step();
    chk_outs("idx19", 1'b0, 20'h80000, 1'b1, 1'b0, 16'd1);
    chk("idx19.FrameData", FrameData, 128'h0000000D_0000000C_0000000B_0000000A);
    drive(1'b0, 32'h0);
    step(); step(); step();
    chk_outs("idx19_idle", 1'b1, 20'h0, 1'b0, 1'b0, 16'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
